drysponge_mix: RTL and testbench

//  Mix phase downstream of the C/X key schedule: absorbs one IWIDTH-bit input block into C using X-word selection.

---
 rtl/drysponge_pkg.sv | 20 ++
 rtl/Gascon_Core_Round.sv | 55 +++++
 rtl/drysponge_mix.sv | 118 +++++++++++
 tb/tb_drysponge_mix.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/drysponge_pkg.sv
// drysponge_pkg: shared types and geometry helpers for the DrySponge mix phase.
package drysponge_pkg;

    typedef enum logic [2:0] {IDLE, MIX, RSTART, RWAIT, OUT} mix_state_t;

    localparam int WORD = 32;

    function automatic int idx_w(input int xwords);
        return $clog2(xwords);
    endfunction

    function automatic int chunk_w(input int cwords, input int xwords);
        return cwords * $clog2(xwords);
    endfunction

    function automatic int steps_n(input int iwidth, input int chunk);
        return (iwidth + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/Gascon_Core_Round.sv
// Gascon_Core_Round: ROUND_COUNT Gascon-style rounds over C, one per clock after reset release.
// done rises ROUND_COUNT cycles after release and holds; cout is the permuted state.
module Gascon_Core_Round #(
    parameter int CWIDTH      = 128,
    parameter int ROUND_COUNT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CWIDTH-1:0] c,
    input  logic              round,
    output logic [CWIDTH-1:0] cout,
    output logic              done
);
    localparam int NW   = CWIDTH / 32;
    localparam int CNTW = $clog2(ROUND_COUNT + 1);

    logic [CWIDTH-1:0] r_s;
    logic [CNTW-1:0]   r_cnt;
    logic              r_done;
    logic [3:0]        w_rc;

    // Constant add on the middle word, chi-like nonlinear layer, then per-word rotate-xor diffusion.
    function automatic logic [CWIDTH-1:0] gascon(input logic [CWIDTH-1:0] s_in, input logic [3:0] rc);
        logic [CWIDTH-1:0] s, t, o;
        logic [31:0]       a;
        s = s_in;
        s[(NW/2)*32 +: 8] = s_in[(NW/2)*32 +: 8] ^ {~rc, rc};
        t = '0;
        o = '0;
        for (int i = 0; i < NW; i++)
            t[i*32 +: 32] = s[i*32 +: 32] ^ (~s[((i+1)%NW)*32 +: 32] & s[((i+2)%NW)*32 +: 32]);
        for (int i = 0; i < NW; i++) begin
            a = t[i*32 +: 32];
            o[i*32 +: 32] = a ^ {a[6:0], a[31:7]} ^ {a[16:0], a[31:17]};
        end
        return o;
    endfunction

    assign w_rc = 4'(r_cnt) + {3'b000, round};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_s    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!r_done) begin
            r_s    <= gascon(r_cnt == '0 ? c : r_s, w_rc);
            r_cnt  <= r_cnt + 1'b1;
            r_done <= int'(r_cnt) == ROUND_COUNT - 1;
        end

    assign cout = r_s;
    assign done = r_done;

endmodule

// File: rtl/drysponge_mix.sv
// drysponge_mix: absorbs one data block into C by XOR-ing index-selected X words,
// with a Gascon round between consecutive chunks (none after the last).
module drysponge_mix
    import drysponge_pkg::*;
#(
    parameter int CWIDTH      = 128,
    parameter int XWIDTH      = 64,
    parameter int IWIDTH      = 128,
    parameter int ROUND_COUNT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CWIDTH-1:0] c_in,
    input  logic [XWIDTH-1:0] x_in,
    input  logic [IWIDTH-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CWIDTH-1:0] c_out,
    output logic [XWIDTH-1:0] x_out,
    output logic              busy
);
    localparam int CWORDS = CWIDTH / WORD;
    localparam int XWORDS = XWIDTH / WORD;
    localparam int IDXW   = idx_w(XWORDS);
    localparam int CHUNK  = chunk_w(CWORDS, XWORDS);
    localparam int STEPS  = steps_n(IWIDTH, CHUNK);
    localparam int PW     = STEPS * CHUNK;
    localparam int SW     = $clog2(STEPS + 1);

    mix_state_t        r_state, w_next;
    logic [CWIDTH-1:0] r_c, r_c_out, w_c_mix, w_core_c;
    logic [XWIDTH-1:0] r_x, r_x_out;
    logic [PW-1:0]     r_data;
    logic [SW-1:0]     r_step;
    logic [CHUNK-1:0]  w_chunk;
    logic              r_core_rst, r_out_valid, r_in_ready, r_busy;
    logic              w_core_rst, w_done;

    assign w_chunk    = r_data[int'(r_step)*CHUNK +: CHUNK];
    assign w_core_rst = reset | r_core_rst;

    always_comb begin
        w_c_mix = r_c;
        for (int w = 0; w < CWORDS; w++)
            w_c_mix[w*WORD +: WORD] = r_c[w*WORD +: WORD] ^ r_x[int'(w_chunk[w*IDXW +: IDXW])*WORD +: WORD];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? MIX : IDLE;
            MIX:     w_next = int'(r_step) == STEPS - 1 ? OUT : RSTART;
            RSTART:  w_next = RWAIT;
            RWAIT:   w_next = w_done ? MIX : RWAIT;
            OUT:     w_next = out_ready ? IDLE : OUT;
            default: w_next = IDLE;
        endcase
    end

    // The core stays in reset everywhere except RWAIT, so each step starts from a fresh C.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state     <= IDLE;
            r_c         <= '0;
            r_x         <= '0;
            r_data      <= '0;
            r_step      <= '0;
            r_core_rst  <= 1'b1;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_c_out     <= '0;
            r_x_out     <= '0;
        end else begin
            r_state     <= w_next;
            r_core_rst  <= w_next != RWAIT;
            r_out_valid <= w_next == OUT;
            r_in_ready  <= w_next == IDLE;
            r_busy      <= w_next != IDLE;
            if (r_state == IDLE && in_valid) begin
                r_c    <= c_in;
                r_x    <= x_in;
                r_data <= PW'(data_in);
                r_step <= '0;
            end
            if (r_state == MIX)
                r_c <= w_c_mix;
            if (r_state == MIX && w_next == OUT) begin
                r_c_out <= w_c_mix;
                r_x_out <= r_x;
            end
            if (r_state == RWAIT && w_done) begin
                r_c    <= w_core_c;
                r_step <= r_step + 1'b1;
            end
        end

    Gascon_Core_Round #(
        .CWIDTH      (CWIDTH),
        .ROUND_COUNT (ROUND_COUNT)
    ) u_core (
        .clk   (clk),
        .c     (r_c),
        .cout  (w_core_c),
        .round (1'b0),
        .reset (w_core_rst),
        .done  (w_done)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign c_out     = r_c_out;
    assign x_out     = r_x_out;

endmodule

// File: tb/tb_drysponge_mix.sv
// tb_drysponge_mix: random and directed blocks against a behavioural mix model, plus a 4-bit-block instance.
module tb_drysponge_mix;
    localparam int STEPS = 32;
    localparam int LCORE = 2;
    localparam int LAT   = STEPS + (STEPS - 1) * (1 + LCORE) + 1;

    logic         clk = 1'b0, reset = 1'b1;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready, busy;
    logic [127:0] c_in = '0, data_in = '0, c_out;
    logic [63:0]  x_in = '0, x_out;
    logic         s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1, s_busy;
    logic [127:0] s_c_in = '0, s_c_out;
    logic [63:0]  s_x_in = '0, s_x_out;
    logic [3:0]   s_data = '0;
    logic         bp_rand = 1'b0, or_fix = 1'b1, rnd_bit = 1'b1;

    int n_chk = 0, n_fail = 0, cyc = 0, last_acc = 0, last_hs = 0;
    logic prev_ov = 1'b0;

    typedef struct {
        logic [127:0] c;
        logic [63:0]  x;
        int           acc;
    } exp_t;
    exp_t q[$];

    assign out_ready = bp_rand ? rnd_bit : or_fix;

    drysponge_mix u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .c_in(c_in), .x_in(x_in), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .c_out(c_out), .x_out(x_out), .busy(busy)
    );

    drysponge_mix #(.IWIDTH(4)) u_small (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .c_in(s_c_in), .x_in(s_x_in), .data_in(s_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .c_out(s_c_out), .x_out(s_x_out), .busy(s_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] a, input int n);
        return (a >> n) | (a << (32 - n));
    endfunction

    function automatic logic [127:0] gascon_round(input logic [127:0] c, input int r);
        logic [31:0] v[4], t[4];
        logic [127:0] o;
        for (int i = 0; i < 4; i++) v[i] = c[i*32 +: 32];
        v[2] = v[2] ^ 32'((15 - r) * 16 + r);
        for (int i = 0; i < 4; i++) t[i] = v[i] ^ (~v[(i+1)%4] & v[(i+2)%4]);
        for (int i = 0; i < 4; i++) o[i*32 +: 32] = t[i] ^ rotr(t[i], 7) ^ rotr(t[i], 17);
        return o;
    endfunction

    // Four C words, one index bit each per step; data beyond iw reads as zero.
    function automatic logic [127:0] mix_model(input logic [127:0] c, input logic [63:0] x,
                                               input logic [127:0] d, input int iw);
        int steps = (iw + 3) / 4;
        for (int s = 0; s < steps; s++) begin
            for (int w = 0; w < 4; w++) begin
                int b = s * 4 + w;
                logic sel = (b < iw) ? d[b] : 1'b0;
                c[w*32 +: 32] = c[w*32 +: 32] ^ (sel ? x[63:32] : x[31:0]);
            end
            if (s < steps - 1) c = gascon_round(c, 0);
        end
        return c;
    endfunction

    always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

    always @(posedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready) begin
                q.push_back('{mix_model(c_in, x_in, data_in, 128), x_in, cyc});
                last_acc = cyc;
            end
            if (out_valid && out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                last_hs = cyc;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready_vs_busy", in_ready, !busy);
            check("busy_vs_inflight", busy, q.size() > 0);
            if (out_valid && q.size() > 0) begin
                check("c_out", c_out, q[0].c);
                check("x_out", x_out, q[0].x);
                if (!prev_ov) check("latency", 128'(cyc - q[0].acc), 128'(LAT));
            end
            prev_ov = out_valid;
        end else prev_ov = 1'b0;
    end

    task automatic send(input logic [127:0] c, input logic [63:0] x, input logic [127:0] d);
        int n = 0;
        @(negedge clk);
        c_in = c; x_in = x; data_in = d; in_valid = 1'b1;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: in_ready stuck at 0");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        c_in = {4{$urandom}}; x_in = {2{$urandom}}; data_in = {4{$urandom}};
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q.size() > 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_budget", n < budget, 1'b1);
    endtask

    initial begin
        logic [127:0] rc, rd;
        logic [63:0]  rx;
        int n;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_c_out", c_out, '0);
        check("rst_x_out", x_out, '0);
        check("rst_small_out_valid", s_out_valid, 1'b0);
        check("model_round_pin", gascon_round('0, 0), 128'h00000000_E07800F1_00000000_E07800F1);
        check("model_t1_pin", mix_model('0, {32'hBBBBBBBB, 32'hAAAAAAAA}, 128'b1010, 4),
              128'hBBBBBBBB_AAAAAAAA_BBBBBBBB_AAAAAAAA);
        reset = 1'b0;

        // Single-step instance: no core rounds, result two cycles after accept.
        @(negedge clk);
        s_x_in = {32'hBBBBBBBB, 32'hAAAAAAAA}; s_data = 4'b1010; s_in_valid = 1'b1;
        check("small_in_ready", s_in_ready, 1'b1);
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("small_latency", 128'(n), 128'd2);
        check("small_c_out", s_c_out, 128'hBBBBBBBB_AAAAAAAA_BBBBBBBB_AAAAAAAA);
        check("small_x_out", s_x_out, {64'h0, 32'hBBBBBBBB, 32'hAAAAAAAA});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_c_in = {4{$urandom}}; s_x_in = {2{$urandom}}; s_data = 4'($urandom); s_in_valid = 1'b1;
            rc = s_c_in; rx = s_x_in; rd = 128'(s_data);
            @(posedge clk);
            #1 s_in_valid = 1'b0;
            repeat (2) @(negedge clk);
            check("small_rand_valid", s_out_valid, 1'b1);
            check("small_rand_c_out", s_c_out, mix_model(rc, rx, rd, 4));
        end

        send('0, {32'h1, 32'h2}, '0);
        wait_idle(400);

        // Backpressure: result must hold while the consumer stalls.
        or_fix = 1'b0;
        send({4{$urandom}}, {2{$urandom}}, {4{$urandom}});
        n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        or_fix = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1'b1);
        check("bp_release_out_valid", out_valid, 1'b0);

        // Reset during RWAIT of step 5 (cycles 23..24 after accept).
        rc = {4{$urandom}}; rx = {2{$urandom}}; rd = {4{$urandom}};
        send(rc, rx, rd);
        repeat (22) @(posedge clk);
        #3;
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        q.delete();
        check("async_out_valid", out_valid, 1'b0);
        check("async_in_ready", in_ready, 1'b1);
        check("async_busy", busy, 1'b0);
        check("async_c_out", c_out, '0);
        check("async_x_out", x_out, '0);
        @(negedge clk);
        reset = 1'b0;
        send(rc, rx, rd);
        wait_idle(400);

        // Back-to-back with in_valid held: second accept one cycle after the handshake.
        @(negedge clk);
        c_in = {4{$urandom}}; x_in = {2{$urandom}}; data_in = {4{$urandom}}; in_valid = 1'b1;
        @(posedge clk);
        #1;
        c_in = {4{$urandom}}; x_in = {2{$urandom}}; data_in = {4{$urandom}};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 400);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("b2b_accept_gap", 128'(last_acc - last_hs), 128'd1);
        wait_idle(400);

        // in_valid pulses while busy must be ignored.
        send({4{$urandom}}, {2{$urandom}}, {4{$urandom}});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; data_in = {4{$urandom}};
            @(negedge clk);
            in_valid = 1'b0;
        end
        wait_idle(400);

        bp_rand = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send({4{$urandom}}, {2{$urandom}}, {4{$urandom}});
            wait_idle(600);
        end
        bp_rand = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
